// File: rtl/reaction_controller.sv
// ---------------------------------------------------------------------------
// reaction_controller
//   Reaction-time game controller. A rising edge on start arms a round: after
//   a (optionally pseudo-random) delay the LED lights and the controller
//   counts milliseconds until the player presses the button, or until the
//   reaction timeout expires. A press before the LED lights is a false start.
//
// Ports
//   clk           in   1   system clock
//   reset         in   1   synchronous, active-low reset
//   start         in   1   level input, rising edge begins a round
//   button        in   1   level input (already synchronised), rising edge = press
//   led_on        out  1   stimulus LED, high only while waiting for the press
//   reaction_ms   out  14  measured reaction time in ms
//   result_valid  out  1   one-cycle pulse when reaction_ms becomes final
//   false_start   out  1   high while the round ended in a false start
//   busy          out  1   high while a round is in progress
// ---------------------------------------------------------------------------
module reaction_controller #(
  parameter int CLKS_PER_MS  = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_EN      = 1,
  parameter int MAX_REACT_MS = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        button,
  output logic        led_on,
  output logic [13:0] reaction_ms,
  output logic        result_valid,
  output logic        false_start,
  output logic        busy
);

  localparam int PW = ($clog2(CLKS_PER_MS) > 16) ? $clog2(CLKS_PER_MS) : 16;
  localparam logic [PW-1:0] PRESC_LAST   = PW'(CLKS_PER_MS - 1);
  localparam logic [13:0]   MIN_DELAY    = 14'(MIN_DELAY_MS);
  localparam logic [13:0]   MAX_REACT    = 14'(MAX_REACT_MS);
  localparam logic [13:0]   MAX_REACT_M1 = 14'(MAX_REACT_MS - 1);
  localparam logic [15:0]   LFSR_SEED    = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_REACT = 3'd2,
    S_DONE  = 3'd3,
    S_FOUL  = 3'd4
  } state_t;

  // Fibonacci LFSR step, taps 16,14,13,11 (bits 15,13,12,10), shifting left.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    lfsr_next = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  state_t         r_state;
  logic [PW-1:0]  r_presc;
  logic [13:0]    r_delay;
  logic [13:0]    r_reaction_ms;
  logic [15:0]    r_lfsr;
  logic           r_start_prev;
  logic           r_button_prev;
  logic           r_led_on;
  logic           r_result_valid;
  logic           r_false_start;
  logic           r_busy;

  state_t         w_state_nxt;
  logic [PW-1:0]  w_presc_nxt;
  logic [13:0]    w_delay_nxt;
  logic [13:0]    w_react_nxt;
  logic [13:0]    w_rand_add;
  logic           w_valid_nxt;
  logic           w_start_edge;
  logic           w_button_edge;
  logic           w_tick;
  logic           w_enter_delay;

  assign w_start_edge  = start  & ~r_start_prev;
  assign w_button_edge = button & ~r_button_prev;
  assign w_tick        = (r_presc == PRESC_LAST);
  assign w_rand_add    = (RAND_EN != 0) ? {2'b00, r_lfsr[11:0]} : 14'd0;
  assign w_enter_delay = (w_state_nxt == S_DELAY) && (r_state != S_DELAY);

  // Next state, delay counter, reaction counter and completion pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_delay_nxt = r_delay;
    w_react_nxt = r_reaction_ms;
    w_valid_nxt = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_FOUL: begin
        if (w_start_edge) begin
          w_state_nxt = S_DELAY;
          w_delay_nxt = MIN_DELAY + w_rand_add;
          w_react_nxt = 14'd0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_DELAY: begin
        // An early press wins over the delay expiring on the same edge.
        if (w_button_edge) begin
          w_state_nxt = S_FOUL;
        end else if (w_tick) begin
          if (r_delay == 14'd1) begin
            w_state_nxt = S_REACT;
            w_delay_nxt = 14'd0;
          end else begin
            w_delay_nxt = r_delay - 14'd1;
          end
        end else begin
          w_delay_nxt = r_delay;
        end
      end
      S_REACT: begin
        // A press on a tick edge freezes the count without that tick.
        if (w_button_edge) begin
          w_state_nxt = S_DONE;
          w_valid_nxt = 1'b1;
        end else if (w_tick) begin
          if (r_reaction_ms >= MAX_REACT_M1) begin
            w_react_nxt = MAX_REACT;
            w_state_nxt = S_DONE;
            w_valid_nxt = 1'b1;
          end else begin
            w_react_nxt = r_reaction_ms + 14'd1;
          end
        end else begin
          w_react_nxt = r_reaction_ms;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Millisecond prescaler; restarts on each round so the first tick is a full ms away.
  always_comb begin
    w_presc_nxt = r_presc;
    if (w_enter_delay) begin
      w_presc_nxt = '0;
    end else if (w_tick) begin
      w_presc_nxt = '0;
    end else begin
      w_presc_nxt = r_presc + PW'(1);
    end
  end

  // State, counters, edge history and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_presc        <= '0;
      r_delay        <= 14'd0;
      r_reaction_ms  <= 14'd0;
      r_lfsr         <= LFSR_SEED;
      // Previous values start high so inputs held through reset give no edge.
      r_start_prev   <= 1'b1;
      r_button_prev  <= 1'b1;
      r_led_on       <= 1'b0;
      r_result_valid <= 1'b0;
      r_false_start  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_presc        <= w_presc_nxt;
      r_delay        <= w_delay_nxt;
      r_reaction_ms  <= w_react_nxt;
      r_lfsr         <= lfsr_next(r_lfsr);
      r_start_prev   <= start;
      r_button_prev  <= button;
      r_led_on       <= (w_state_nxt == S_REACT);
      r_result_valid <= w_valid_nxt;
      r_false_start  <= (w_state_nxt == S_FOUL);
      r_busy         <= (w_state_nxt == S_DELAY) || (w_state_nxt == S_REACT);
    end
  end

  assign led_on       = r_led_on;
  assign reaction_ms  = r_reaction_ms;
  assign result_valid = r_result_valid;
  assign false_start  = r_false_start;
  assign busy         = r_busy;

endmodule

// File: tb/tb_reaction_controller.sv
// ---------------------------------------------------------------------------
// tb_reaction_controller
//   Self-checking bench. Instance A uses a fixed delay (RAND_EN=0), instance B
//   a random delay (RAND_EN=1); both use CLKS_PER_MS=4, MIN_DELAY_MS=3,
//   MAX_REACT_MS=20. Expected reaction times are queued when the press (or
//   timeout) is set up and popped when result_valid pulses.
// ---------------------------------------------------------------------------
module tb_reaction_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, button_a, start_b, button_b;
  logic        led_on_a, result_valid_a, false_start_a, busy_a;
  logic        led_on_b, result_valid_b, false_start_b, busy_b;
  logic [13:0] reaction_ms_a, reaction_ms_b;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [13:0] exp_a[$];
  logic [13:0] exp_b[$];
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  reaction_controller #(
    .CLKS_PER_MS(4), .MIN_DELAY_MS(3), .RAND_EN(0), .MAX_REACT_MS(20)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .button(button_a),
    .led_on(led_on_a), .reaction_ms(reaction_ms_a), .result_valid(result_valid_a),
    .false_start(false_start_a), .busy(busy_a)
  );

  reaction_controller #(
    .CLKS_PER_MS(4), .MIN_DELAY_MS(3), .RAND_EN(1), .MAX_REACT_MS(20)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .button(button_b),
    .led_on(led_on_b), .reaction_ms(reaction_ms_b), .result_valid(result_valid_b),
    .false_start(false_start_b), .busy(busy_b)
  );

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1.
  function automatic logic [15:0] ref_lfsr(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  always @(posedge clk) begin
    if (!reset) m_lfsr <= 16'hACE1;
    else        m_lfsr <= ref_lfsr(m_lfsr);
  end

  // Scoreboard for instance A: every result pulse must match a queued expectation.
  always @(negedge clk) begin
    if (result_valid_a === 1'b1) begin
      n_checks++;
      if (exp_a.size() == 0) begin
        n_fail++;
        $display("FAIL result_a_unexpected: reaction_ms=%0d, no result expected", reaction_ms_a);
      end else begin
        logic [13:0] e;
        e = exp_a.pop_front();
        if (reaction_ms_a !== e) begin
          n_fail++;
          $display("FAIL result_a: reaction_ms=%0d expected %0d", reaction_ms_a, e);
        end
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    if (result_valid_b === 1'b1) begin
      n_checks++;
      if (exp_b.size() == 0) begin
        n_fail++;
        $display("FAIL result_b_unexpected: reaction_ms=%0d, no result expected", reaction_ms_b);
      end else begin
        logic [13:0] e;
        e = exp_b.pop_front();
        if (reaction_ms_b !== e) begin
          n_fail++;
          $display("FAIL result_b: reaction_ms=%0d expected %0d", reaction_ms_b, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare a packed value against its expectation (inline helper-free style via macro-like task body).
  task automatic test_reset();
    reset = 1'b0; start_a = 1'b1; button_a = 1'b1; start_b = 1'b0; button_b = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({led_on_a, busy_a, result_valid_a, false_start_a, reaction_ms_a} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got led=%b busy=%b valid=%b foul=%b ms=%0d expected all 0",
               led_on_a, busy_a, result_valid_a, false_start_a, reaction_ms_a);
    end
    reset = 1'b1;
    repeat (3) step();
    n_checks++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held_start: busy=%b expected 0", busy_a);
    end
  endtask

  task automatic test_normal();
    start_a = 1'b0; button_a = 1'b0; step();
    start_a = 1'b1; step();
    n_checks++;
    if (busy_a !== 1'b1 || led_on_a !== 1'b0) begin
      n_fail++;
      $display("FAIL normal_start: busy=%b led=%b expected busy=1 led=0", busy_a, led_on_a);
    end
    repeat (11) step();
    n_checks++;
    if (led_on_a !== 1'b0) begin
      n_fail++;
      $display("FAIL normal_led_early: led=%b at cycle 11 expected 0", led_on_a);
    end
    step();
    n_checks++;
    if (led_on_a !== 1'b1) begin
      n_fail++;
      $display("FAIL normal_led_rise: led=%b at cycle 12 expected 1", led_on_a);
    end
    repeat (40) step();
    n_checks++;
    if (reaction_ms_a !== 14'd10) begin
      n_fail++;
      $display("FAIL normal_count: reaction_ms=%0d expected 10", reaction_ms_a);
    end
    button_a = 1'b1;
    exp_a.push_back(14'd10);
    step();
    n_checks++;
    if (led_on_a !== 1'b0 || busy_a !== 1'b0 || result_valid_a !== 1'b1 || reaction_ms_a !== 14'd10) begin
      n_fail++;
      $display("FAIL normal_done: led=%b busy=%b valid=%b ms=%0d expected 0 0 1 10",
               led_on_a, busy_a, result_valid_a, reaction_ms_a);
    end
    step();
    n_checks++;
    if (result_valid_a !== 1'b0 || reaction_ms_a !== 14'd10) begin
      n_fail++;
      $display("FAIL normal_pulse_len: valid=%b ms=%0d expected 0 10", result_valid_a, reaction_ms_a);
    end
    button_a = 1'b0;
  endtask

  task automatic test_false_start();
    start_a = 1'b0; step();
    start_a = 1'b1; step();
    repeat (4) step();
    button_a = 1'b1; step();
    n_checks++;
    if (false_start_a !== 1'b1 || busy_a !== 1'b0 || led_on_a !== 1'b0) begin
      n_fail++;
      $display("FAIL foul_enter: foul=%b busy=%b led=%b expected 1 0 0", false_start_a, busy_a, led_on_a);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (led_on_a !== 1'b0) begin
        n_fail++;
        $display("FAIL foul_led: led=%b at cycle %0d after foul expected 0", led_on_a, i);
      end
    end
    start_a = 1'b0; button_a = 1'b0; step();
    start_a = 1'b1; step();
    n_checks++;
    if (false_start_a !== 1'b0 || busy_a !== 1'b1 || reaction_ms_a !== 14'd0) begin
      n_fail++;
      $display("FAIL foul_restart: foul=%b busy=%b ms=%0d expected 0 1 0", false_start_a, busy_a, reaction_ms_a);
    end
    button_a = 1'b1; step();
    n_checks++;
    if (false_start_a !== 1'b1) begin
      n_fail++;
      $display("FAIL foul_again: foul=%b expected 1", false_start_a);
    end
  endtask

  task automatic test_timeout();
    start_a = 1'b0; button_a = 1'b0; step();
    start_a = 1'b1; step();
    // Drop and re-raise start mid-delay: that edge must not restart the round.
    for (int i = 1; i <= 11; i++) begin
      start_a = (i == 5) ? 1'b0 : 1'b1;
      step();
    end
    n_checks++;
    if (led_on_a !== 1'b0 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_delay: led=%b busy=%b expected 0 1", led_on_a, busy_a);
    end
    step();
    n_checks++;
    if (led_on_a !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_led: led=%b expected 1 (start edge in delay must be ignored)", led_on_a);
    end
    exp_a.push_back(14'd20);
    repeat (79) step();
    n_checks++;
    if (reaction_ms_a !== 14'd19 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_pre: ms=%0d busy=%b expected 19 1", reaction_ms_a, busy_a);
    end
    step();
    n_checks++;
    if (reaction_ms_a !== 14'd20 || busy_a !== 1'b0 || led_on_a !== 1'b0 || result_valid_a !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_done: ms=%0d busy=%b led=%b valid=%b expected 20 0 0 1",
               reaction_ms_a, busy_a, led_on_a, result_valid_a);
    end
    button_a = 1'b1; step(); step();
    n_checks++;
    if (reaction_ms_a !== 14'd20 || false_start_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL done_button_ignored: ms=%0d foul=%b busy=%b expected 20 0 0",
               reaction_ms_a, false_start_a, busy_a);
    end
    button_a = 1'b0;
  endtask

  task automatic test_coincidence();
    start_a = 1'b0; button_a = 1'b0; step();
    start_a = 1'b1; step();
    repeat (12) step();
    repeat (19) step();
    button_a = 1'b1;
    exp_a.push_back(14'd4);
    step();
    n_checks++;
    if (reaction_ms_a !== 14'd4 || result_valid_a !== 1'b1) begin
      n_fail++;
      $display("FAIL coinc_tick: ms=%0d valid=%b expected 4 1", reaction_ms_a, result_valid_a);
    end
    start_a = 1'b0; button_a = 1'b0; step();
    start_a = 1'b1; step();
    repeat (11) step();
    button_a = 1'b1; step();
    n_checks++;
    if (false_start_a !== 1'b1 || led_on_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL coinc_expiry: foul=%b led=%b busy=%b expected 1 0 0", false_start_a, led_on_a, busy_a);
    end
    button_a = 1'b0;
  endtask

  task automatic test_reset_mid_react();
    start_a = 1'b0; button_a = 1'b0; step();
    start_a = 1'b1; step();
    repeat (12) step();
    repeat (28) step();
    n_checks++;
    if (reaction_ms_a !== 14'd7 || led_on_a !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_pre: ms=%0d led=%b expected 7 1", reaction_ms_a, led_on_a);
    end
    reset = 1'b0; step();
    n_checks++;
    if ({led_on_a, busy_a, result_valid_a, false_start_a, reaction_ms_a} !== 18'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: led=%b busy=%b valid=%b foul=%b ms=%0d expected all 0",
               led_on_a, busy_a, result_valid_a, false_start_a, reaction_ms_a);
    end
    reset = 1'b1;
    repeat (5) step();
    n_checks++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_start_held: busy=%b expected 0", busy_a);
    end
    start_a = 1'b0; step();
    start_a = 1'b1; step();
    n_checks++;
    if (busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_restart: busy=%b expected 1", busy_a);
    end
    button_a = 1'b1; step();
    button_a = 1'b0; step();
  endtask

  task automatic test_random_delay();
    for (int r = 0; r < 2; r++) begin
      logic [15:0] lv;
      int          want;
      int          cnt;
      start_b = 1'b0; button_b = 1'b0; step();
      lv = m_lfsr;
      start_b = 1'b1; step();
      want = 4 * (3 + int'(lv[11:0]));
      cnt = 0;
      while (led_on_b !== 1'b1 && cnt < 20000) begin
        step();
        cnt++;
      end
      n_checks++;
      if (cnt != want) begin
        n_fail++;
        $display("FAIL random_delay round %0d: delay=%0d cycles expected %0d", r, cnt, want);
      end
      button_b = 1'b1;
      exp_b.push_back(14'd0);
      step();
      n_checks++;
      if (busy_b !== 1'b0 || reaction_ms_b !== 14'd0) begin
        n_fail++;
        $display("FAIL random_done round %0d: busy=%b ms=%0d expected 0 0", r, busy_b, reaction_ms_b);
      end
    end
    button_b = 1'b0; step();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_false_start();
    test_timeout();
    test_coincidence();
    test_reset_mid_react();
    test_random_delay();
    repeat (3) step();
    n_checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      n_fail++;
      $display("FAIL pending_results: %0d/%0d expected results never produced, expected 0/0",
               exp_a.size(), exp_b.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
